// File: rtl/vga_capture.sv
// vga_capture: recovers pixel coordinates from a sampled VGA stream.
// Tracks hsync/vsync edges in the pixel-clock domain and emits a one-cycle
// write strobe per active pixel. Also reports lock and line/frame length errors.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_START  = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_START  = 32,
    parameter int V_TOTAL  = 525
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] color_in,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [7:0] pix_data,
    output logic       frame_start,
    output logic       frame_done,
    output logic       locked,
    output logic       line_err,
    output logic       frame_err
);

    localparam logic [9:0]  LP_CNT_MAX   = 10'h3FF;
    localparam logic [9:0]  LP_H_FIRST   = 10'(H_START);
    localparam logic [9:0]  LP_H_LAST    = 10'(H_START + H_ACTIVE - 1);
    localparam logic [9:0]  LP_X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  LP_Y_LAST    = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  LP_V_START   = 10'(V_START);
    localparam logic [9:0]  LP_V_FRONT   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  LP_V_RUNAWAY = 10'(V_TOTAL + 8);
    localparam logic [10:0] LP_H_TOTAL   = 11'(H_TOTAL);
    localparam logic [10:0] LP_V_TOTAL   = 11'(V_TOTAL);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_BACK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FRONT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Sync edge detection: bit 0 = hsync, bit 1 = vsync.
    logic [1:0] w_sync_in;
    logic [1:0] w_sync_rise;
    logic       w_h_rise;
    logic       w_v_rise;

    assign w_sync_in = {vsync, hsync};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic r_sync_d;
            // Previous sample of this sync line; idles high so reset never fakes an edge.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sync_d <= 1'b1;
                end else begin
                    r_sync_d <= w_sync_in[gi];
                end
            end
            assign w_sync_rise[gi] = w_sync_in[gi] & ~r_sync_d;
        end
    endgenerate

    assign w_h_rise = w_sync_rise[0];
    assign w_v_rise = w_sync_rise[1];

    // Horizontal position: value for the current cycle (0 on the hsync rise).
    logic [9:0]  r_h_cnt;
    logic [9:0]  w_h_cnt;
    logic        w_h_len_bad;

    assign w_h_cnt     = w_h_rise ? 10'd0 :
                         ((r_h_cnt == LP_CNT_MAX) ? r_h_cnt : r_h_cnt + 10'd1);
    // r_h_cnt still holds the last count of the line that just ended.
    assign w_h_len_bad = (({1'b0, r_h_cnt} + 11'd1) != LP_H_TOTAL);

    // Vertical position. r_v_pend marks "vsync seen, first hsync edge not yet",
    // so the first edge after a vsync rise yields line 0.
    logic [9:0]  r_v_cnt;
    logic        r_v_pend;
    logic [9:0]  w_v_cnt_next;
    logic        w_v_pend_next;
    logic [10:0] w_frame_lines;

    assign w_frame_lines = r_v_pend ? 11'd0 : ({1'b0, r_v_cnt} + 11'd1);

    // Status tracking.
    logic r_armed;   // a line start has been seen since leaving SEARCH
    logic r_clean;   // no error since the last vsync rise
    logic w_line_err;
    logic w_frame_err;
    logic w_frame_ok;

    // Next-state and vertical bookkeeping; vsync handling overrides hsync.
    always_comb begin
        w_state_next  = r_state;
        w_v_cnt_next  = r_v_cnt;
        w_v_pend_next = r_v_pend;
        w_frame_err   = 1'b0;
        w_frame_ok    = 1'b0;
        w_line_err    = w_h_rise && r_armed && w_h_len_bad;

        if (w_v_rise) begin
            // A coincident hsync edge is line 0 of the new frame.
            w_v_cnt_next  = 10'd0;
            w_v_pend_next = ~w_h_rise;
            case (r_state)
                ST_SEARCH: ;
                ST_FRONT: begin
                    if (w_frame_lines != LP_V_TOTAL) begin
                        w_frame_err = 1'b1;
                    end else begin
                        w_frame_ok = 1'b1;
                    end
                end
                default: w_frame_err = 1'b1;  // vsync before the active region ended
            endcase
            if (w_h_rise && (LP_V_START == 10'd0)) begin
                w_state_next = ST_ACTIVE;
            end else begin
                w_state_next = ST_BACK;
            end
        end else if (w_h_rise) begin
            if (r_v_pend) begin
                w_v_cnt_next  = 10'd0;
                w_v_pend_next = 1'b0;
            end else if (r_v_cnt != LP_CNT_MAX) begin
                w_v_cnt_next = r_v_cnt + 10'd1;
            end
            case (r_state)
                ST_BACK: begin
                    if (w_v_cnt_next == LP_V_START) begin
                        w_state_next = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_v_cnt_next == LP_V_FRONT) begin
                        w_state_next = ST_FRONT;
                    end
                end
                default: ;
            endcase
            // vsync went missing: give up on this frame and hunt again.
            if ((r_state != ST_SEARCH) && (w_v_cnt_next == LP_V_RUNAWAY)) begin
                w_frame_err  = 1'b1;
                w_state_next = ST_SEARCH;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pixel selection uses the post-edge line so x=0 works even when H_START is 0.
    logic       w_cap;
    logic [9:0] w_x;
    logic [9:0] w_y;

    assign w_cap = (w_state_next == ST_ACTIVE) &&
                   (w_h_cnt >= LP_H_FIRST) && (w_h_cnt <= LP_H_LAST);
    assign w_x   = w_h_cnt - LP_H_FIRST;
    assign w_y   = w_v_cnt_next - LP_V_START;

    logic       r_pix_valid;
    logic [9:0] r_pix_x;
    logic [9:0] r_pix_y;
    logic [7:0] r_pix_data;
    logic       r_frame_start;
    logic       r_frame_done;
    logic       r_locked;
    logic       r_line_err;
    logic       r_frame_err;

    // Counters, status flags and the registered output stream.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_v_pend      <= 1'b0;
            r_armed       <= 1'b0;
            r_clean       <= 1'b0;
            r_locked      <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_pix_data    <= 8'd0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_h_cnt  <= w_h_cnt;
            r_v_cnt  <= w_v_cnt_next;
            r_v_pend <= w_v_pend_next;

            if (w_state_next == ST_SEARCH) begin
                r_armed <= 1'b0;
            end else if (w_h_rise) begin
                r_armed <= 1'b1;
            end

            // An error on the vsync edge itself is charged to the frame that ended.
            if (w_v_rise) begin
                r_clean <= 1'b1;
            end else if (w_line_err || w_frame_err) begin
                r_clean <= 1'b0;
            end

            if (w_line_err || w_frame_err) begin
                r_locked <= 1'b0;
            end else if (w_frame_ok && r_clean) begin
                r_locked <= 1'b1;
            end

            r_line_err  <= w_line_err;
            r_frame_err <= w_frame_err;

            r_pix_valid   <= w_cap;
            r_frame_start <= w_cap && (w_x == 10'd0) && (w_y == 10'd0);
            r_frame_done  <= w_cap && (w_x == LP_X_LAST) && (w_y == LP_Y_LAST);
            if (w_cap) begin
                r_pix_x    <= w_x;
                r_pix_y    <= w_y;
                r_pix_data <= color_in;
            end
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_data    = r_pix_data;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign locked      = r_locked;
    assign line_err    = r_line_err;
    assign frame_err   = r_frame_err;

endmodule
